// File: rtl/fp_div32_pkg.sv
// Shared single-precision constants, field widths and enums for the FP datapath.
// The fp_div32 rounding mode is selected by the FP_DIV32_RNE_EN macro.
package fp32_pkg;

    localparam int unsigned FP32_BIAS = 127;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned FRAC_W    = 23;
    localparam int unsigned MANT_W    = 24;
    localparam int unsigned QUO_W     = 26;

    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP32_PINF = 32'h7F800000;

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM} state_t;

    typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp32_class_t;

endpackage

// File: rtl/fp_div32_if.sv
// Operand/result handshake bundle between the calculator control and fp_div32.
interface fp_div32_if;
    logic        load;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;
    logic        done;
    logic        busy;

    modport master (output load, A, B, input result, done, busy);
    modport slave  (input load, A, B, output result, done, busy);
endinterface

// File: rtl/fp_div32_classify.sv
// Combinational unpack of an IEEE-754 single into sign, exponent, {1,frac} and class.
// Denormals are reported as ZERO (flush-to-zero datapath).
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0]       x_i,
    output logic              sign_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic [MANT_W-1:0] mant_o,
    output fp32_class_t       cls_o
);
    logic [FRAC_W-1:0] frac;

    assign sign_o = x_i[31];
    assign exp_o  = x_i[30:23];
    assign frac   = x_i[22:0];
    assign mant_o = {1'b1, frac};

    always_comb begin
        cls_o = NORMAL;
        if (exp_o == '0)
            cls_o = ZERO;
        else if (exp_o == '1)
            cls_o = (frac == '0) ? INF : NAN;
    end
endmodule

// File: rtl/fp_div32.sv
// Iterative single-precision divider: 26-cycle restoring mantissa divide, then
// normalize/round/pack. FP_DIV32_RNE_EN selects round-to-nearest-even, else truncate.
module fp_div32
    import fp32_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    fp_div32_if.slave  bus
);
    logic              sa, sb;
    logic [EXP_W-1:0]  ea, eb;
    logic [MANT_W-1:0] ma, mb;
    fp32_class_t       ca, cb;

    fp32_classify u_cls_a (.x_i(bus.A), .sign_o(sa), .exp_o(ea), .mant_o(ma), .cls_o(ca));
    fp32_classify u_cls_b (.x_i(bus.B), .sign_o(sb), .exp_o(eb), .mant_o(mb), .cls_o(cb));

    state_t              state_q, state_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic signed [9:0]   exp_q, exp_d;
    logic [QUO_W-1:0]    rem_q, rem_d;
    logic [QUO_W-1:0]    q_q, q_d;
    logic [MANT_W-1:0]   mb_q, mb_d;
    logic                spec_q, spec_d;
    logic [31:0]         spec_val_q, spec_val_d;
    logic [31:0]         result_q, result_d;
    logic                done_q, done_d;

    logic [QUO_W-1:0]    rem_sub;
    logic                rem_ge;
    logic [31:0]         spec_val;
    logic [31:0]         packed_res;

    // Specials are decided at accept time and only substituted at retire.
    always_comb begin
        spec_val = {sa ^ sb, 31'd0};
        if (ca == NAN || cb == NAN || (ca == ZERO && cb == ZERO) || (ca == INF && cb == INF))
            spec_val = FP32_QNAN;
        else if (cb == ZERO || ca == INF)
            spec_val = {sa ^ sb, FP32_PINF[30:0]};
    end

    assign rem_ge  = (rem_q >= {2'b00, mb_q});
    assign rem_sub = rem_ge ? (rem_q - {2'b00, mb_q}) : rem_q;

    logic [MANT_W-1:0]   mant_n, mant_f;
    logic [MANT_W:0]     rnd;
    logic signed [9:0]   e_n, e_f;
`ifdef FP_DIV32_RNE_EN
    logic                guard, sticky;
`endif

    always_comb begin
        mant_n = q_q[25] ? q_q[25:2] : q_q[24:1];
        e_n    = q_q[25] ? exp_q : exp_q - 10'sd1;
`ifdef FP_DIV32_RNE_EN
        guard  = q_q[25] ? q_q[1] : q_q[0];
        sticky = (q_q[25] & q_q[0]) | (|rem_q);
        rnd    = {1'b0, mant_n} + {{MANT_W{1'b0}}, guard & (sticky | mant_n[0])};
`else
        rnd    = {1'b0, mant_n};
`endif
        mant_f = rnd[MANT_W] ? rnd[MANT_W:1] : rnd[MANT_W-1:0];
        e_f    = rnd[MANT_W] ? e_n + 10'sd1 : e_n;
        if (e_f >= 10'sd255)
            packed_res = {sign_q, FP32_PINF[30:0]};
        else if (e_f <= 10'sd0)
            packed_res = {sign_q, 31'd0};
        else
            packed_res = {sign_q, e_f[7:0], mant_f[FRAC_W-1:0]};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        rem_d      = rem_q;
        q_d        = q_q;
        mb_d       = mb_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    state_d    = DIVIDE;
                    cnt_d      = '0;
                    sign_d     = sa ^ sb;
                    exp_d      = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                    rem_d      = {2'b00, ma};
                    mb_d       = mb;
                    q_d        = '0;
                    spec_d     = (ca != NORMAL) || (cb != NORMAL);
                    spec_val_d = spec_val;
                end
            end
            DIVIDE: begin
                rem_d = {rem_sub[QUO_W-2:0], 1'b0};
                q_d   = {q_q[QUO_W-2:0], rem_ge};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) begin
                    cnt_d   = '0;
                    state_d = NORM;
                end
            end
            NORM: begin
                result_d = spec_q ? spec_val_q : packed_res;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            mb_q       <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
        end else if (en) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            rem_q      <= rem_d;
            q_q        <= q_d;
            mb_q       <= mb_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            result_q   <= result_d;
            done_q     <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state_q != IDLE) | done_q;
endmodule

// File: tb/tb_fp_div32.sv
// Self-checking bench for fp_div32: directed IEEE cases, random operands against
// an exact-division reference model, clock-enable stalls, reset abort, back-to-back.
module tb_fp_div32;
    logic clk;
    logic rst;
    logic en;
    int   errors;
    int   checks;

    fp_div32_if bus ();
    fp_div32 dut (.clk(clk), .rst(rst), .en(en), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e;
        logic [22:0] fa, fb;
        bit za, zb, ia, ib, na, nb, s, g, st, inc;
        longint unsigned num, den, q, r, mant;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = a[22:0];        fb = b[22:0];
        za = (ea == 0);      zb = (eb == 0);
        ia = (ea == 255) && (fa == 0);  ib = (eb == 255) && (fb == 0);
        na = (ea == 255) && (fa != 0);  nb = (eb == 255) && (fb != 0);
        s  = a[31] ^ b[31];
        if (na || nb || (za && zb) || (ia && ib)) return 32'h7FC00000;
        if (zb || ia) return {s, 8'hFF, 23'd0};
        if (za || ib) return {s, 31'd0};
        num = longint'({1'b1, fa}) << 25;
        den = longint'({1'b1, fb});
        q = num / den;
        r = num % den;
        e = ea - eb + 127;
        if (q >= (64'd1 << 25)) begin
            mant = q >> 2; g = q[1]; st = q[0] || (r != 0);
        end else begin
            e = e - 1;
            mant = q >> 1; g = q[0]; st = (r != 0);
        end
        inc = g && (st || mant[0]);
`ifndef FP_DIV32_RNE_EN
        inc = 1'b0;
`endif
        mant = mant + longint'(inc);
        if (mant >= (64'd1 << 24)) begin
            mant = mant >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], mant[22:0]};
    endfunction

    // Issues one operation and reports the edge count (after accept) until done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        @(negedge clk);
        bus.load = 1'b1; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.load = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        res = bus.result;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; bus.load = 1'b0; bus.A = '0; bus.B = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected %h", bus.result, 32'h0); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] da [14];
        logic [31:0] db [14];
        logic [31:0] dx [14];
        logic [31:0] res;
        logic [31:0] third;
        int lat;
`ifdef FP_DIV32_RNE_EN
        third = 32'h3EAAAAAB;
`else
        third = 32'h3EAAAAAA;
`endif
        da = '{32'h40C00000, 32'h3F800000, 32'hC1000000, 32'h3F800000, 32'h00000000,
               32'h7F000000, 32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h3F800000,
               32'h00000001, 32'h00800000, 32'h80000000, 32'hBF800000};
        db = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h00000000, 32'h00000000,
               32'h00800000, 32'h3F800000, 32'h7F800000, 32'h3F800000, 32'hFF800000,
               32'h3F800000, 32'h7F000000, 32'h3F800000, 32'h00000000};
        dx = '{32'h40400000, third,        32'hC1800000, 32'h7F800000, 32'h7FC00000,
               32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000,
               32'h00000000, 32'h00000000, 32'h80000000, 32'hFF800000};
        for (int i = 0; i < 14; i++) begin
            run_op(da[i], db[i], res, lat);
            checks++;
            if (lat != 27) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected 27", i, lat); end
            checks++;
            if (res !== dx[i]) begin errors++; $display("FAIL directed_result[%0d] %h/%h: got %h expected %h", i, da[i], db[i], res, dx[i]); end
            @(posedge clk); #1;
            checks++;
            if (bus.done !== 1'b0) begin errors++; $display("FAIL directed_done_pulse[%0d]: got %b expected 0", i, bus.done); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp_v;
        int lat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                a[30:23] = 8'($urandom_range(100, 154));
                b[30:23] = 8'($urandom_range(100, 154));
            end
            if ($urandom_range(0, 7) == 0) b[22:0] = '0;
            exp_v = ref_div(a, b);
            run_op(a, b, res, lat);
            checks++;
            if (lat != 27) begin errors++; $display("FAIL random_latency[%0d]: got %0d expected 27", i, lat); end
            checks++;
            if (res !== exp_v) begin errors++; $display("FAIL random_result[%0d] %h/%h: got %h expected %h", i, a, b, res, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat;
        run_op(32'h40C00000, 32'h40000000, res, lat);
        @(negedge clk);
        bus.load = 1'b1; bus.A = 32'hC1000000; bus.B = 32'h3F000000;
        @(posedge clk); #1;
        bus.load = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_at_accept: got %b expected 1", bus.busy); end
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin lat = i; break; end
        end
        checks++;
        if (lat != 27) begin errors++; $display("FAIL b2b_latency: got %0d expected 27", lat); end
        checks++;
        if (bus.result !== 32'hC1800000) begin errors++; $display("FAIL b2b_result: got %h expected %h", bus.result, 32'hC1800000); end
    endtask

    task automatic test_en_stall();
        int lat;
        @(negedge clk);
        bus.load = 1'b1; bus.A = 32'h40C00000; bus.B = 32'h40000000;
        @(posedge clk); #1;
        bus.load = 1'b0;
        lat = -1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            en = (i >= 10 && i < 15) ? 1'b0 : 1'b1;
            bus.load = (i == 3);
            if (i == 3) begin bus.A = 32'h3F800000; bus.B = 32'h40400000; end
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin lat = i; break; end
        end
        bus.load = 1'b0;
        checks++;
        if (lat != 32) begin errors++; $display("FAIL stall_latency: got %0d expected 32", lat); end
        checks++;
        if (bus.result !== 32'h40400000) begin errors++; $display("FAIL stall_result: got %h expected %h", bus.result, 32'h40400000); end
        @(negedge clk); en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL stall_done_held: got %b expected 1", bus.done); end
        @(negedge clk); en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL stall_done_drop: got %b expected 0", bus.done); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL ignored_load_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_abort_reset();
        logic [31:0] res;
        int lat;
        bit saw_done;
        @(negedge clk);
        bus.load = 1'b1; bus.A = 32'h40C00000; bus.B = 32'h40000000;
        @(posedge clk); #1;
        bus.load = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.result !== 32'h0) begin errors++; $display("FAIL abort_result: got %h expected %h", bus.result, 32'h0); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
        @(negedge clk); rst = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL abort_no_done: got done=1 expected done=0"); end
        run_op(32'hC1000000, 32'h3F000000, res, lat);
        checks++;
        if (lat != 27) begin errors++; $display("FAIL post_abort_latency: got %0d expected 27", lat); end
        checks++;
        if (res !== 32'hC1800000) begin errors++; $display("FAIL post_abort_result: got %h expected %h", res, 32'hC1800000); end
        @(negedge clk);
        rst = 1'b0; bus.load = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_load_same_edge: got busy=%b expected 0", bus.busy); end
        @(negedge clk);
        rst = 1'b1; bus.load = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_load_after: got busy=%b expected 0", bus.busy); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_en_stall();
        test_abort_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
